// File: rtl/rv32_pkg.sv
// Shared RV32I load/store encodings, fault codes and the LSU state type.
package rv32_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replicated write data, plus load
// byte/half selection with sign or zero extension.
module lsu_align
    import rv32_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] store_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_value
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wstrb = 4'b0000;
        wdata = 32'h0000_0000;
        case (st_funct3)
            FUNCT3_SB: begin
                wstrb = 4'b0001 << st_offset;
                wdata = {4{store_data[7:0]}};
            end
            FUNCT3_SH: begin
                wstrb = st_offset[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            FUNCT3_SW: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wstrb = 4'b0000;
                wdata = 32'h0000_0000;
            end
        endcase
    end

    always_comb begin
        shifted    = rdata >> {ld_offset, 3'b000};
        byte_sel   = shifted[7:0];
        half_sel   = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        load_value = 32'h0000_0000;
        case (ld_funct3)
            FUNCT3_LB:  load_value = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LH:  load_value = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LW:  load_value = rdata;
            FUNCT3_LBU: load_value = {24'h00_0000, byte_sel};
            FUNCT3_LHU: load_value = {16'h0000, half_sel};
            default:    load_value = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Runs one load or store per instruction on a valid/ready data bus, stalling
// the core until the bus answers and flagging bad or timed-out accesses.
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              fault,
    output logic [1:0]        fault_code,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_we,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic              bus_rsp_valid,
    input  logic [31:0]       bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    lsu_state state, next_state;

    logic             req, is_write, legal, illegal, misaligned, bad, bad_now;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit, abort;
    logic             timed_out;
    logic [2:0]       funct3_q;
    logic [1:0]       offset_q;
    logic [31:0]      load_q;
    logic [3:0]       align_wstrb;
    logic [31:0]      align_wdata, align_load;

    assign req      = mem_read | mem_write;
    assign is_write = mem_write & ~mem_read;

    always_comb begin
        legal = 1'b0;
        if (mem_read) begin
            case (funct3)
                FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end else if (mem_write) begin
            case (funct3)
                FUNCT3_SB, FUNCT3_SH, FUNCT3_SW: legal = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

    assign illegal    = req & ~legal;
    assign misaligned = req & (((funct3[1:0] == 2'b01) & addr[0]) |
                               ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00)));
    assign bad        = illegal | misaligned;
    assign bad_now    = (state == IDLE) & bad;

    // The counter saturates so a late accept cannot wrap it past the limit.
    assign timeout_hit = TIMEOUT_EN && (cnt >= TIMEOUT_LAST);
    assign abort = timeout_hit &&
                   (((state == REQ) && !bus_req_ready) || ((state == WAIT) && !bus_rsp_valid));

    lsu_align u_align (
        .st_funct3  (funct3),
        .st_offset  (addr[1:0]),
        .store_data (store_data),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .ld_funct3  (funct3_q),
        .ld_offset  (offset_q),
        .rdata      (bus_rdata),
        .load_value (align_load)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req && !bad) next_state = REQ;
            REQ:  if (bus_req_ready) next_state = WAIT;
                  else if (abort)    next_state = DONE;
            WAIT: if (bus_rsp_valid || abort) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus_req_valid = ~rst & (state == REQ);
        stall         = ~rst & req & (state != DONE) & ~bad;
        fault         = 1'b0;
        fault_code    = FAULT_NONE;
        if (!rst && req && bad_now) begin
            fault      = 1'b1;
            fault_code = illegal ? FAULT_ILLEGAL : FAULT_MISALIGN;
        end else if (!rst && (state == DONE) && timed_out) begin
            fault      = 1'b1;
            fault_code = FAULT_TIMEOUT;
        end
        load_data = (req && bad_now) ? 32'h0000_0000 : load_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            timed_out <= 1'b0;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            bus_wdata <= 32'h0000_0000;
            funct3_q  <= 3'b000;
            offset_q  <= 2'b00;
            load_q    <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    timed_out <= 1'b0;
                    if (req && !bad) begin
                        bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus_we    <= is_write;
                        bus_wstrb <= is_write ? align_wstrb : 4'b0000;
                        bus_wdata <= is_write ? align_wdata : 32'h0000_0000;
                        funct3_q  <= funct3;
                        offset_q  <= addr[1:0];
                    end
                end
                REQ, WAIT: begin
                    if (!TIMEOUT_EN || (cnt != TIMEOUT_LAST)) cnt <= cnt + 1'b1;
                    if ((state == WAIT) && bus_rsp_valid) begin
                        load_q <= bus_we ? 32'h0000_0000 : align_load;
                    end else if (abort) begin
                        load_q    <= 32'h0000_0000;
                        timed_out <= 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a bus responder per access, plus
// directed checks for bad accesses, timeout and mid-transaction reset.
module tb_load_store_unit;
    import rv32_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, load_data;
    logic        stall, fault;
    logic [1:0]  fault_code;
    logic        bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] load;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TIMEOUT), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .load_data(load_data), .stall(stall), .fault(fault), .fault_code(fault_code),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*off +: 8];
        h = w[16*off[1] +: 16];
        case (f3)
            FUNCT3_LB:  return {{24{b[7]}}, b};
            FUNCT3_LBU: return {24'h0, b};
            FUNCT3_LH:  return {{16{h[15]}}, h};
            FUNCT3_LHU: return {16'h0, h};
            default:    return w;
        endcase
    endfunction

    // Drives one access starting in IDLE and plays the bus; ends in the IDLE cycle after DONE.
    task automatic run_access(input logic r, input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                              input int ready_wait, input logic [31:0] exp_load,
                              input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
        exp_t e;
        int   stall_cycles = 0;
        int   valid_cycles = 0;
        bit   seen = 0, in_wait = 0, done = 0;
        e.addr  = {a[31:2], 2'b00};
        e.we    = w & ~r;
        e.wstrb = exp_wstrb;
        e.wdata = exp_wdata;
        e.load  = exp_load;
        sb.push_back(e);
        mem_read = r; mem_write = w; funct3 = f3; addr = a; store_data = sd;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            #1;
            bus_req_ready = 1'b0;
            bus_rsp_valid = 1'b0;
            if (in_wait) begin
                bus_rsp_valid = 1'b1;
                bus_rdata     = rd;
                in_wait       = 0;
            end
            if (!stall) begin
                done = 1;
            end else begin
                stall_cycles++;
                if (bus_req_valid) begin
                    if (!seen) begin
                        seen = 1;
                        checks++;
                        if (bus_addr !== sb[0].addr || bus_we !== sb[0].we ||
                            (sb[0].we && (bus_wstrb !== sb[0].wstrb || bus_wdata !== sb[0].wdata))) begin
                            failures++;
                            $display("[TB] FAIL bus_fields: got addr=%h we=%b wstrb=%b wdata=%h, want addr=%h we=%b wstrb=%b wdata=%h",
                                     bus_addr, bus_we, bus_wstrb, bus_wdata,
                                     sb[0].addr, sb[0].we, sb[0].wstrb, sb[0].wdata);
                        end
                    end
                    if (valid_cycles >= ready_wait) begin
                        bus_req_ready = 1'b1;
                        in_wait       = 1;
                    end
                    valid_cycles++;
                end
                @(negedge clk);
            end
        end
        e = sb.pop_front();
        checks++;
        if (!done || !seen) begin
            failures++;
            $display("[TB] FAIL access_complete: done=%0d bus_seen=%0d, want 1 1", done, seen);
        end
        checks++;
        if (stall_cycles != 3 + ready_wait) begin
            failures++;
            $display("[TB] FAIL stall_cycles: got %0d want %0d", stall_cycles, 3 + ready_wait);
        end
        checks++;
        if (load_data !== e.load || fault !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_result @%h: got data=%h fault=%b, want data=%h fault=0",
                     a, load_data, fault, e.load);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = 32'h0;
        store_data = 32'h0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        mem_read = 1'b1; funct3 = FUNCT3_LW; addr = 32'h10;
        #1;
        checks++;
        if ({load_data, stall, fault, fault_code, bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got ld=%h stall=%b fault=%b code=%b valid=%b addr=%h we=%b strb=%b wd=%h, want all 0",
                     load_data, stall, fault, fault_code, bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata);
        end
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        run_access(1'b0, 1'b1, FUNCT3_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0,
                   32'h0, 4'b1111, 32'hDEADBEEF);
    endtask

    task automatic test_load_byte();
        run_access(1'b1, 1'b0, FUNCT3_LB,  32'h203, 32'h0, 32'h80FF1234, 0, 32'hFFFFFF80, 4'h0, 32'h0);
        run_access(1'b1, 1'b0, FUNCT3_LBU, 32'h203, 32'h0, 32'h80FF1234, 1, 32'h00000080, 4'h0, 32'h0);
    endtask

    task automatic test_half();
        run_access(1'b0, 1'b1, FUNCT3_SH,  32'h12, 32'h0000ABCD, 32'h0, 0, 32'h0, 4'b1100, 32'hABCDABCD);
        run_access(1'b1, 1'b0, FUNCT3_LHU, 32'h12, 32'h0, 32'hBEEF0000, 0, 32'h0000BEEF, 4'h0, 32'h0);
        run_access(1'b1, 1'b0, FUNCT3_LH,  32'h10, 32'h0, 32'h1234F00D, 2, 32'hFFFFF00D, 4'h0, 32'h0);
    endtask

    task automatic test_read_wins();
        // funct3 100 is illegal as a store, so a surviving write would fault.
        run_access(1'b1, 1'b1, FUNCT3_LBU, 32'h401, 32'hFFFFFFFF, 32'h0000A500, 0,
                   32'h000000A5, 4'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [2:0]  lf3  [4] = '{FUNCT3_LB, FUNCT3_LBU, FUNCT3_LH, FUNCT3_LHU};
        logic [3:0]  strb [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [31:0] rd, sd;
        logic [1:0]  off;
        for (int i = 0; i < 16; i++) begin
            rd  = $urandom;
            off = 2'(i % 4);
            if (i >= 8) off = off & 2'b10;
            run_access(1'b1, 1'b0, lf3[i/4], 32'h500 + 32'(off), 32'h0, rd, i % 3,
                       model_load(lf3[i/4], off, rd), 4'h0, 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            sd = $urandom;
            run_access(1'b0, 1'b1, FUNCT3_SB, 32'h600 + 32'(i), sd, 32'h0, i % 2,
                       32'h0, strb[i], {4{sd[7:0]}});
        end
    endtask

    task automatic test_bad_access();
        logic        tr [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        tw [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  tf [5] = '{FUNCT3_LW, 3'b011, FUNCT3_LH, 3'b110, FUNCT3_SW};
        logic [31:0] ta [5] = '{32'h101, 32'h103, 32'h205, 32'h200, 32'h102};
        logic [1:0]  tc [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        run_access(1'b1, 1'b0, FUNCT3_LW, 32'h700, 32'h0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 4'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            mem_read = tr[i]; mem_write = tw[i]; funct3 = tf[i]; addr = ta[i];
            #1;
            checks++;
            if ({stall, bus_req_valid, fault, fault_code} !== {1'b0, 1'b0, 1'b1, tc[i]} ||
                load_data !== 32'h0) begin
                failures++;
                $display("[TB] FAIL bad_access_%0d: got stall=%b valid=%b fault=%b code=%b ld=%h, want 0 0 1 %b 00000000",
                         i, stall, bus_req_valid, fault, fault_code, load_data, tc[i]);
            end
            @(negedge clk);
        end
        mem_read = 1'b0; mem_write = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || bus_req_valid !== 1'b0 || load_data !== 32'hCAFEF00D) begin
            failures++;
            $display("[TB] FAIL bad_access_after: got fault=%b valid=%b ld=%h, want 0 0 cafef00d",
                     fault, bus_req_valid, load_data);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int stall_cycles = 0;
        int valid_cycles = 0;
        bit done = 0;
        mem_read = 1'b1; mem_write = 1'b0; funct3 = FUNCT3_LW; addr = 32'h40;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            #1;
            if (!stall) done = 1;
            else begin
                stall_cycles++;
                if (bus_req_valid) valid_cycles++;
                @(negedge clk);
            end
        end
        checks++;
        if (!done || valid_cycles != TIMEOUT || stall_cycles != TIMEOUT + 1) begin
            failures++;
            $display("[TB] FAIL timeout_length: got done=%0d valid_cycles=%0d stall_cycles=%0d, want 1 %0d %0d",
                     done, valid_cycles, stall_cycles, TIMEOUT, TIMEOUT + 1);
        end
        checks++;
        if ({fault, fault_code} !== 3'b111 || load_data !== 32'h0 || bus_req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_done: got fault=%b code=%b ld=%h valid=%b, want 1 11 00000000 0",
                     fault, fault_code, load_data, bus_req_valid);
        end
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (fault !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_idle: got fault=%b stall=%b, want 0 0", fault, stall);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        run_access(1'b1, 1'b0, FUNCT3_LW, 32'h300, 32'h0, 32'h12345678, 0, 32'h12345678, 4'h0, 32'h0);
        mem_read = 1'b1; mem_write = 1'b0; funct3 = FUNCT3_LW; addr = 32'h304;
        @(negedge clk);
        bus_req_ready = 1'b1;
        #1;
        checks++;
        if (bus_req_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid_req: got valid=%b want 1", bus_req_valid);
        end
        @(negedge clk);
        bus_req_ready = 1'b0; rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({load_data, stall, fault, fault_code, bus_req_valid, bus_addr, bus_we, bus_wstrb, bus_wdata} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_outputs: got ld=%h stall=%b fault=%b valid=%b addr=%h, want all 0",
                     load_data, stall, fault, bus_req_valid, bus_addr);
        end
        rst = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        #1;
        checks++;
        if (load_data !== 32'h0 || stall !== 1'b0 || bus_req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL late_response: got ld=%h stall=%b valid=%b, want 00000000 0 0",
                     load_data, stall, bus_req_valid);
        end
        @(negedge clk);
        run_access(1'b1, 1'b0, FUNCT3_LW, 32'h308, 32'h0, 32'h0BADC0DE, 1, 32'h0BADC0DE, 4'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_byte();
        test_half();
        test_read_wins();
        test_back_to_back();
        test_bad_access();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Responder to the control decoder's mem_read/mem_write outputs in the single-cycle RV32I core.
- Accepts one load or store per instruction and runs it on a valid/ready data-bus port.
- Stalls the core until the bus responds.
- Aligns and extends load data by funct3, generates byte strobes for stores, and flags misaligned, illegal or timed-out accesses.

Parameters:
- TIMEOUT_CYCLES, 64: max cycles in REQ+WAIT before abort; 0 disables the timeout.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- mem_read  in  1  load request from control decoder
- mem_write  in  1  store request from control decoder
- funct3  in  3  access width/sign (instr[14:12])
- addr  in  ADDR_W  byte address from ALU
- store_data  in  32  rs2 value
- load_data  out  32  aligned/extended load result, valid when stall=0
- stall  out  1  hold PC and register write-back
- fault  out  1  one-cycle pulse: access abandoned
- fault_code  out  2  01 misaligned, 10 illegal funct3, 11 bus timeout
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_addr  out  ADDR_W  word-aligned address (addr[1:0]=0)
- bus_we  out  1  1=write
- bus_wstrb  out  4  byte lane enables
- bus_wdata  out  32  lane-replicated store data
- bus_rsp_valid  in  1  read data / write ack
- bus_rdata  in  32  read word

Behaviour:
- Reset: state IDLE, all outputs 0, timeout counter 0. Reset mid-transaction aborts at once; a later bus_rsp_valid is ignored.
- req = mem_read | mem_write. If both are high, the read wins and the write is ignored.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- stall = req & (state!=DONE) & ~bad, where bad = misaligned | illegal. stall is combinational (Mealy).
- Bad access in IDLE:
  - No bus activity, stall=0.
  - fault=1 for that cycle, with fault_code as above (illegal beats misaligned).
  - load_data=0.
- FSM:
  - IDLE: if req & ~bad, register bus_addr, bus_we, bus_wstrb, bus_wdata and funct3/addr[1:0]; go to REQ.
  - REQ: bus_req_valid=1 with fields held stable. On bus_req_ready, go to WAIT.
  - WAIT: bus_req_valid=0. On bus_rsp_valid, capture formatted load_data (stores: 0) and go to DONE.
  - DONE: stall=0 for exactly one cycle, then go to IDLE. The core retires the instruction on this edge.
- bus_rsp_valid in IDLE or REQ is ignored; responses arrive no earlier than the cycle after the accept.
- Minimum latency: req at cycle 0, REQ at 1 (ready=1), WAIT at 2 (rsp=1), DONE at 3. stall is high for cycles 0–2.
- Strobes:
  - SB: 0001<<addr[1:0].
  - SH: 0011<<(2*addr[1]).
  - SW: 1111.
- wdata: SB replicates byte ×4; SH replicates half ×2.
- Loads: select the byte/half by the registered addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Timeout:
  - The counter increments in REQ/WAIT and clears in IDLE.
  - When it reaches TIMEOUT_CYCLES: drop bus_req_valid, go to DONE with load_data=0, and pulse fault (code 11) in DONE.
- load_data holds its value until the next capture.

Decomposition:
- Package rv32_pkg holds:
  - FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW constants.
  - FAULT_MISALIGN/ILLEGAL/TIMEOUT codes.
  - lsu_state enum (IDLE, REQ, WAIT, DONE).
- One combinational sub-module, lsu_align: strobe/wdata generation plus load extraction/extension. The FSM, timeout counter and capture registers stay in load_store_unit.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, ready and ack on the first cycle -> wstrb=1111, bus_addr=0x100, stall high 3 cycles, no fault.
- LB addr=0x203, rdata=0x80FF1234 -> wstrb unused, load_data=0xFFFFFF80; LBU same access -> 0x00000080.
- SH addr=0x12, data=0x0000ABCD -> wstrb=1100, wdata=0xABCDABCD; LHU addr=0x12, rdata=0xBEEF0000 -> 0x0000BEEF.
- LW addr=0x101 -> no bus_req_valid, stall=0, fault=1, code=01. Store with funct3=011 -> fault code 10.
- bus_req_ready held 0, TIMEOUT_CYCLES=4 -> bus_req_valid drops after 4 cycles, DONE with fault code 11, then IDLE.
- rst asserted in WAIT, then a late bus_rsp_valid -> state IDLE, all outputs 0, response ignored; a following LW completes normally.
